// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: one BRAM port shared by loads and committed stores, 2-cycle load pipeline with ROB flush.
// Optional macro DMEM_ARB_SUBWORD_EN adds LB/LH/LHU loads and SH stores.
module dmem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_ld_req_valid,
  output logic        o_ld_req_ready,
  input  logic [31:0] i_ld_addr,
  input  logic [2:0]  i_ld_func3,
  input  logic [4:0]  i_ld_rob_tag,
  input  logic [6:0]  i_ld_pd,
  input  logic        i_st_req_valid,
  output logic        o_st_req_ready,
  input  logic [31:0] i_st_addr,
  input  logic [31:0] i_st_wdata,
  input  logic [2:0]  i_st_func3,
  output logic        o_mem_en,
  output logic [3:0]  o_mem_we,
  output logic [29:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_ld_resp_valid,
  output logic [31:0] o_ld_resp_data,
  output logic [4:0]  o_ld_resp_rob_tag,
  output logic [6:0]  o_ld_resp_pd,
  input  logic        i_mispredict,
  input  logic [4:0]  i_mispredict_tag,
  input  logic [4:0]  i_curr_rob_tag
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] r_starve_cnt;
  logic          r_s1_valid, r_s2_valid;
  logic [4:0]    r_s1_tag, r_s2_tag;
  logic [6:0]    r_s1_pd, r_s2_pd;
  logic [2:0]    r_s1_func3, r_s2_func3;
  logic [1:0]    r_s1_off, r_s2_off;

  logic        w_ld_blocked, w_ld_prio, w_ld_grant, w_st_grant;
  logic        w_s1_kill, w_s2_kill;
  logic [7:0]  w_byte;
  logic [31:0] w_ld_data;

  // Tag strictly inside the circular window (lo, hi); lo == hi is an empty window.
  function automatic logic in_window(input logic [4:0] tag, input logic [4:0] lo,
                                     input logic [4:0] hi);
    logic [4:0] d, w;
    d = tag - lo;
    w = hi - lo;
    return (d != 5'd0) && (d < w);
  endfunction

  assign w_ld_blocked = i_mispredict && in_window(i_ld_rob_tag, i_mispredict_tag, i_curr_rob_tag);
  assign w_ld_prio    = (r_starve_cnt == CW'(STARVE_MAX));
  assign w_s1_kill    = i_mispredict && in_window(r_s1_tag, i_mispredict_tag, i_curr_rob_tag);
  assign w_s2_kill    = i_mispredict && in_window(r_s2_tag, i_mispredict_tag, i_curr_rob_tag);

  assign o_ld_req_ready = ~i_reset & ~w_ld_blocked & (w_ld_prio | ~i_st_req_valid);
  assign o_st_req_ready = ~i_reset & ~(w_ld_prio & i_ld_req_valid & ~w_ld_blocked);
  assign w_ld_grant     = i_ld_req_valid & o_ld_req_ready;
  assign w_st_grant     = i_st_req_valid & o_st_req_ready;

  always_comb begin
    o_mem_en    = 1'b0;
    o_mem_we    = 4'b0000;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_st_grant) begin
      o_mem_en    = 1'b1;
      o_mem_addr  = i_st_addr[31:2];
      o_mem_wdata = i_st_wdata;
      case (i_st_func3)
        3'b010: o_mem_we = 4'b1111;
        3'b000: begin
          o_mem_we    = 4'b0001 << i_st_addr[1:0];
          o_mem_wdata = {4{i_st_wdata[7:0]}};
        end
`ifdef DMEM_ARB_SUBWORD_EN
        3'b001: begin
          o_mem_we    = i_st_addr[1] ? 4'b1100 : 4'b0011;
          o_mem_wdata = {2{i_st_wdata[15:0]}};
        end
`endif
        default: o_mem_we = 4'b0000;
      endcase
    end else if (w_ld_grant) begin
      o_mem_en   = 1'b1;
      o_mem_addr = i_ld_addr[31:2];
    end
  end

`ifdef DMEM_ARB_SUBWORD_EN
  logic [15:0] w_half;
  assign w_half = r_s2_off[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
`endif

  assign w_byte = i_mem_rdata[{r_s2_off, 3'b000} +: 8];

  always_comb begin
    w_ld_data = '0;
    case (r_s2_func3)
      3'b010: w_ld_data = i_mem_rdata;
      3'b100: w_ld_data = {24'd0, w_byte};
`ifdef DMEM_ARB_SUBWORD_EN
      3'b000: w_ld_data = {{24{w_byte[7]}}, w_byte};
      3'b001: w_ld_data = {{16{w_half[15]}}, w_half};
      3'b101: w_ld_data = {16'd0, w_half};
`endif
      default: w_ld_data = '0;
    endcase
  end

  // S2 lines up with the BRAM read data; a flush in that same cycle still hides it.
  assign o_ld_resp_valid   = r_s2_valid & ~w_s2_kill;
  assign o_ld_resp_data    = o_ld_resp_valid ? w_ld_data : '0;
  assign o_ld_resp_rob_tag = o_ld_resp_valid ? r_s2_tag : '0;
  assign o_ld_resp_pd      = o_ld_resp_valid ? r_s2_pd : '0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_starve_cnt <= '0;
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s1_tag     <= '0;
      r_s2_tag     <= '0;
      r_s1_pd      <= '0;
      r_s2_pd      <= '0;
      r_s1_func3   <= '0;
      r_s2_func3   <= '0;
      r_s1_off     <= '0;
      r_s2_off     <= '0;
    end else begin
      r_s1_valid <= w_ld_grant;
      if (w_ld_grant) begin
        r_s1_tag   <= i_ld_rob_tag;
        r_s1_pd    <= i_ld_pd;
        r_s1_func3 <= i_ld_func3;
        r_s1_off   <= i_ld_addr[1:0];
      end
      r_s2_valid <= r_s1_valid & ~w_s1_kill;
      r_s2_tag   <= r_s1_tag;
      r_s2_pd    <= r_s1_pd;
      r_s2_func3 <= r_s1_func3;
      r_s2_off   <= r_s1_off;
      if (w_ld_grant || !i_ld_req_valid)
        r_starve_cnt <= '0;
      else if (w_st_grant && !w_ld_prio)
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a 2-cycle-latency BRAM model.
module tb_dmem_arbiter;

  logic        clk, reset;
  logic        ld_req_valid, ld_req_ready;
  logic [31:0] ld_addr;
  logic [2:0]  ld_func3;
  logic [4:0]  ld_rob_tag;
  logic [6:0]  ld_pd;
  logic        st_req_valid, st_req_ready;
  logic [31:0] st_addr, st_wdata;
  logic [2:0]  st_func3;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic [4:0]  ld_resp_rob_tag;
  logic [6:0]  ld_resp_pd;
  logic        mispredict;
  logic [4:0]  mispredict_tag, curr_rob_tag;

  int checks = 0;
  int errors = 0;

  dmem_arbiter #(.STARVE_MAX(4)) dut (
    .i_clk(clk), .i_reset(reset),
    .i_ld_req_valid(ld_req_valid), .o_ld_req_ready(ld_req_ready),
    .i_ld_addr(ld_addr), .i_ld_func3(ld_func3), .i_ld_rob_tag(ld_rob_tag), .i_ld_pd(ld_pd),
    .i_st_req_valid(st_req_valid), .o_st_req_ready(st_req_ready),
    .i_st_addr(st_addr), .i_st_wdata(st_wdata), .i_st_func3(st_func3),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_rdata(mem_rdata),
    .o_ld_resp_valid(ld_resp_valid), .o_ld_resp_data(ld_resp_data),
    .o_ld_resp_rob_tag(ld_resp_rob_tag), .o_ld_resp_pd(ld_resp_pd),
    .i_mispredict(mispredict), .i_mispredict_tag(mispredict_tag), .i_curr_rob_tag(curr_rob_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: byte-enabled write, read data two cycles after the read cycle.
  logic [31:0] mem [0:15];
  logic [31:0] rd_p1;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[0] <= 32'h44332211;
    end else if (mem_en) begin
      if (mem_we == 4'b0000) rd_p1 <= mem[mem_addr[3:0]];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr[3:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    mem_rdata <= rd_p1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ld_req_valid = 0; ld_addr = 0; ld_func3 = 0; ld_rob_tag = 0; ld_pd = 0;
    st_req_valid = 0; st_addr = 0; st_wdata = 0; st_func3 = 0;
    mispredict = 0; mispredict_tag = 0; curr_rob_tag = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [2:0] f, input logic [4:0] t,
                      input logic [6:0] p);
    ld_req_valid = 1; ld_addr = a; ld_func3 = f; ld_rob_tag = t; ld_pd = p;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    ld_req_valid = 1; st_req_valid = 1; st_func3 = 3'b010;
    @(negedge clk);
    checks++;
    if (ld_req_ready !== 1'b0 || st_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready ld=%b st=%b expected 0 0", ld_req_ready, st_req_ready);
    end
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 4'b0 || mem_addr !== 30'd0 || mem_wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_mem en=%b we=%b addr=%h wdata=%h expected all 0",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (ld_resp_valid !== 1'b0 || ld_resp_data !== 32'd0 || ld_resp_rob_tag !== 5'd0 ||
        ld_resp_pd !== 7'd0) begin
      errors++;
      $display("FAIL reset_resp v=%b d=%h t=%0d p=%0d expected all 0",
               ld_resp_valid, ld_resp_data, ld_resp_rob_tag, ld_resp_pd);
    end
    idle();
    step(); step();
    reset = 0;
    step();
  endtask

  task automatic test_lw();
    idle();
    load(32'd0, 3'b010, 5'd1, 7'd10);
    @(negedge clk);
    checks++;
    if (ld_req_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0000 || mem_addr !== 30'd0) begin
      errors++;
      $display("FAIL lw_grant ready=%b en=%b we=%b addr=%h expected 1 1 0000 0",
               ld_req_ready, mem_en, mem_we, mem_addr);
    end
    step(); idle();
    @(negedge clk);
    checks++;
    if (ld_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL lw_early valid=%b expected 0", ld_resp_valid);
    end
    step();
    @(negedge clk);
    checks++;
    if (ld_resp_valid !== 1'b1 || ld_resp_data !== 32'h44332211 || ld_resp_rob_tag !== 5'd1 ||
        ld_resp_pd !== 7'd10) begin
      errors++;
      $display("FAIL lw_resp v=%b d=%h t=%0d p=%0d expected 1 44332211 1 10",
               ld_resp_valid, ld_resp_data, ld_resp_rob_tag, ld_resp_pd);
    end
    step();
    @(negedge clk);
    checks++;
    if (ld_resp_valid !== 1'b0 || ld_resp_data !== 32'd0 || ld_resp_rob_tag !== 5'd0 ||
        ld_resp_pd !== 7'd0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL lw_idle v=%b d=%h t=%0d p=%0d en=%b expected all 0",
               ld_resp_valid, ld_resp_data, ld_resp_rob_tag, ld_resp_pd, mem_en);
    end
  endtask

  task automatic test_back_to_back();
    idle();
    load(32'd0, 3'b010, 5'd2, 7'd11);
    step();
    load(32'd1, 3'b100, 5'd3, 7'd12);
    @(negedge clk);
    checks++;
    if (ld_req_ready !== 1'b1 || mem_addr !== 30'd0) begin
      errors++;
      $display("FAIL b2b_second_grant ready=%b addr=%h expected 1 0", ld_req_ready, mem_addr);
    end
    step(); idle();
    @(negedge clk);
    checks++;
    if (ld_resp_valid !== 1'b1 || ld_resp_data !== 32'h44332211 || ld_resp_rob_tag !== 5'd2) begin
      errors++;
      $display("FAIL b2b_first v=%b d=%h t=%0d expected 1 44332211 2",
               ld_resp_valid, ld_resp_data, ld_resp_rob_tag);
    end
    step();
    @(negedge clk);
    checks++;
    if (ld_resp_valid !== 1'b1 || ld_resp_data !== 32'h00000022 || ld_resp_rob_tag !== 5'd3 ||
        ld_resp_pd !== 7'd12) begin
      errors++;
      $display("FAIL b2b_lbu v=%b d=%h t=%0d p=%0d expected 1 00000022 3 12",
               ld_resp_valid, ld_resp_data, ld_resp_rob_tag, ld_resp_pd);
    end
    step();
  endtask

  task automatic test_sb_then_lw();
    idle();
    st_req_valid = 1; st_addr = 32'd2; st_wdata = 32'h123456AB; st_func3 = 3'b000;
    @(negedge clk);
    checks++;
    if (st_req_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0100 || mem_addr !== 30'd0 ||
        mem_wdata !== 32'hABABABAB) begin
      errors++;
      $display("FAIL sb_drive rdy=%b en=%b we=%b addr=%h wd=%h expected 1 1 0100 0 abababab",
               st_req_ready, mem_en, mem_we, mem_addr, mem_wdata);
    end
    step(); idle();
    load(32'd0, 3'b010, 5'd4, 7'd13);
    step(); idle();
    step();
    @(negedge clk);
    checks++;
    if (ld_resp_valid !== 1'b1 || ld_resp_data !== 32'h44AB2211) begin
      errors++;
      $display("FAIL sb_lw_data v=%b d=%h expected 1 44ab2211", ld_resp_valid, ld_resp_data);
    end
    step();
  endtask

  task automatic test_sw_and_subword();
    logic [31:0] exp_lb, exp_lw;
    logic [3:0]  exp_sh_we;
`ifdef DMEM_ARB_SUBWORD_EN
    exp_lb = 32'hFFFFFFEF; exp_sh_we = 4'b1100; exp_lw = 32'hCAFEBEEF;
`else
    exp_lb = 32'h0;        exp_sh_we = 4'b0000; exp_lw = 32'hDEADBEEF;
`endif
    idle();
    st_req_valid = 1; st_addr = 32'd4; st_wdata = 32'hDEADBEEF; st_func3 = 3'b010;
    @(negedge clk);
    checks++;
    if (mem_we !== 4'b1111 || mem_addr !== 30'd1 || mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_drive we=%b addr=%h wd=%h expected 1111 1 deadbeef",
               mem_we, mem_addr, mem_wdata);
    end
    step(); idle();
    @(negedge clk);
    checks++;
    if (mem_en !== 1'b0 || mem_we !== 4'b0000) begin
      errors++;
      $display("FAIL no_grant_mem en=%b we=%b expected 0 0000", mem_en, mem_we);
    end
    load(32'd4, 3'b000, 5'd8, 7'd20);
    step(); idle();
    step();
    @(negedge clk);
    checks++;
    if (ld_resp_valid !== 1'b1 || ld_resp_data !== exp_lb || ld_resp_rob_tag !== 5'd8) begin
      errors++;
      $display("FAIL lb_code v=%b d=%h t=%0d expected 1 %h 8",
               ld_resp_valid, ld_resp_data, ld_resp_rob_tag, exp_lb);
    end
    step();
    st_req_valid = 1; st_addr = 32'd6; st_wdata = 32'h5555CAFE; st_func3 = 3'b001;
    @(negedge clk);
    checks++;
    if (st_req_ready !== 1'b1 || mem_we !== exp_sh_we) begin
      errors++;
      $display("FAIL sh_store rdy=%b we=%b expected 1 %b", st_req_ready, mem_we, exp_sh_we);
    end
    step(); idle();
    load(32'd4, 3'b010, 5'd9, 7'd21);
    step(); idle();
    step();
    @(negedge clk);
    checks++;
    if (ld_resp_valid !== 1'b1 || ld_resp_data !== exp_lw) begin
      errors++;
      $display("FAIL sh_effect v=%b d=%h expected 1 %h", ld_resp_valid, ld_resp_data, exp_lw);
    end
    step();
  endtask

  task automatic test_flush();
    logic [4:0]  lo [0:2];
    logic [4:0]  hi [0:2];
    logic [4:0]  tg [0:2];
    logic        ev [0:2];
    lo[0] = 5'd3;  hi[0] = 5'd8; tg[0] = 5'd5;  ev[0] = 1'b0;
    lo[1] = 5'd3;  hi[1] = 5'd8; tg[1] = 5'd9;  ev[1] = 1'b1;
    lo[2] = 5'd30; hi[2] = 5'd2; tg[2] = 5'd31; ev[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle();
      load(32'd0, 3'b010, tg[k], 7'd40);
      step(); idle();
      mispredict = 1; mispredict_tag = lo[k]; curr_rob_tag = hi[k];
      step(); idle();
      @(negedge clk);
      checks++;
      if (ld_resp_valid !== ev[k] || ld_resp_data !== (ev[k] ? 32'h44AB2211 : 32'h0)) begin
        errors++;
        $display("FAIL flush_s1 case=%0d v=%b d=%h expected valid %b", k, ld_resp_valid,
                 ld_resp_data, ev[k]);
      end
      step();
    end
    load(32'd0, 3'b010, 5'd6, 7'd41);
    step(); idle();
    step();
    mispredict = 1; mispredict_tag = 5'd3; curr_rob_tag = 5'd8;
    @(negedge clk);
    checks++;
    if (ld_resp_valid !== 1'b0 || ld_resp_data !== 32'h0) begin
      errors++;
      $display("FAIL flush_s2 v=%b d=%h expected 0 0", ld_resp_valid, ld_resp_data);
    end
    load(32'd0, 3'b010, 5'd4, 7'd42);
    @(negedge clk);
    checks++;
    if (ld_req_ready !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL flush_req_block rdy=%b en=%b expected 0 0", ld_req_ready, mem_en);
    end
    step();
    mispredict_tag = 5'd7; curr_rob_tag = 5'd7; ld_rob_tag = 5'd7;
    @(negedge clk);
    checks++;
    if (ld_req_ready !== 1'b1 || mem_en !== 1'b1) begin
      errors++;
      $display("FAIL flush_empty_window rdy=%b en=%b expected 1 1", ld_req_ready, mem_en);
    end
    step(); idle();
    mispredict = 1; mispredict_tag = 5'd0; curr_rob_tag = 5'd31;
    st_req_valid = 1; st_addr = 32'd12; st_wdata = 32'h0BADF00D; st_func3 = 3'b010;
    @(negedge clk);
    checks++;
    if (st_req_ready !== 1'b1 || mem_we !== 4'b1111) begin
      errors++;
      $display("FAIL flush_store rdy=%b we=%b expected 1 1111", st_req_ready, mem_we);
    end
    step(); idle();
    step(); step();
  endtask

  task automatic test_starvation();
    logic exp_ld;
    idle();
    load(32'd0, 3'b010, 5'd12, 7'd14);
    st_req_valid = 1; st_addr = 32'd8; st_wdata = 32'h11110000; st_func3 = 3'b010;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp_ld = (i == 5);
      checks++;
      if (ld_req_ready !== exp_ld || st_req_ready !== !exp_ld ||
          mem_we !== (exp_ld ? 4'b0000 : 4'b1111)) begin
        errors++;
        $display("FAIL starve cycle=%0d ld_rdy=%b st_rdy=%b we=%b expected ld grant %b",
                 i, ld_req_ready, st_req_ready, mem_we, exp_ld);
      end
      step();
      if (i == 5) ld_req_valid = 0;
    end
    idle();
    step(); step();
  endtask

  task automatic test_reset_inflight();
    idle();
    load(32'd0, 3'b010, 5'd10, 7'd30);
    step();
    load(32'd0, 3'b010, 5'd11, 7'd31);
    step(); idle();
    @(negedge clk);
    checks++;
    if (ld_resp_valid !== 1'b1 || ld_resp_rob_tag !== 5'd10) begin
      errors++;
      $display("FAIL pre_reset_resp v=%b t=%0d expected 1 10", ld_resp_valid, ld_resp_rob_tag);
    end
    reset = 1;
    #1;
    checks++;
    if (ld_resp_valid !== 1'b0 || ld_resp_data !== 32'h0 || ld_resp_rob_tag !== 5'd0 ||
        ld_resp_pd !== 7'd0 || mem_en !== 1'b0 || ld_req_ready !== 1'b0 ||
        st_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset v=%b d=%h t=%0d p=%0d en=%b rdy=%b%b expected all 0",
               ld_resp_valid, ld_resp_data, ld_resp_rob_tag, ld_resp_pd, mem_en,
               ld_req_ready, st_req_ready);
    end
    step();
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (ld_resp_valid !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_resp cycle=%0d v=%b expected 0", i, ld_resp_valid);
      end
      step();
    end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_lw();
    test_back_to_back();
    test_sb_then_lw();
    test_sw_and_subword();
    test_flush();
    test_starvation();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
- REQ-001: Parameter STARVE_MAX, default 4: maximum consecutive store grants while a load waits.
- REQ-002: clk  in  1  Single clock; all state updates on the rising edge.
- REQ-003: reset  in  1  Asynchronous, active-high reset.
- REQ-004: ld_req_valid / ld_req_ready  in / out  1 / 1  Load request handshake from the memory FU.
- REQ-005: ld_addr, ld_func3, ld_rob_tag, ld_pd  in  32, 3, 5, 7  Load byte address, size code, ROB index, destination physical register.
- REQ-006: st_req_valid / st_req_ready  in / out  1 / 1  Committed-store request handshake from ROB retire.
- REQ-007: st_addr, st_wdata, st_func3  in  32, 32, 3  Store byte address, data, size code (010 SW, 000 SB).
- REQ-008: mem_en, mem_we, mem_addr, mem_wdata  out  1, 4, 30, 32  Data BRAM port; mem_addr is a word address.
- REQ-009: mem_rdata  in  32  BRAM read data, valid exactly 2 cycles after a read cycle (mem_en=1, mem_we=0).
- REQ-010: ld_resp_valid, ld_resp_data, ld_resp_rob_tag, ld_resp_pd  out  1, 32, 5, 7  Load completion; no backpressure.
- REQ-011: mispredict, mispredict_tag, curr_rob_tag  in  1, 5, 5  Flush request and ROB tag window.

Function
- REQ-012: A load is granted when ld_req_valid && ld_req_ready in a cycle; a store is granted when st_req_valid && st_req_ready; at most one grant occurs per cycle.
- REQ-013: Arbitration: store has priority over load, except when starve_cnt == STARVE_MAX, in which case load has priority.
- REQ-014: starve_cnt increments on each store grant while ld_req_valid=1, clears on any load grant or when ld_req_valid=0, and saturates at STARVE_MAX.
- REQ-015: Store grant drives the same cycle: mem_en=1, mem_addr=st_addr[31:2], mem_we=1111 with mem_wdata=st_wdata for SW.
- REQ-016: For SB, mem_we is one-hot at st_addr[1:0] and mem_wdata is st_wdata[7:0] replicated to all 4 bytes.
- REQ-017: Load grant drives the same cycle: mem_en=1, mem_we=0000, mem_addr=ld_addr[31:2].
- REQ-018: Load tracking is a 2-stage valid pipeline (S1, S2) carrying tag, pd, func3 and addr[1:0], and accepts one load per cycle.
- REQ-019: ld_resp_valid is registered and asserts in the cycle mem_rdata is valid, i.e. 2 cycles after the grant.
- REQ-020: LW returns mem_rdata; addr[1:0] is ignored.
- REQ-021: LBU returns mem_rdata byte addr[1:0], zero-extended.
- REQ-022: Undecoded func3 still produces ld_resp_valid=1 with ld_resp_data=0.
- REQ-023: When no response is valid, ld_resp_data, ld_resp_rob_tag and ld_resp_pd are 0.
- REQ-024: mem_en=0 and mem_we=0 in cycles with no grant.
- REQ-025: While mispredict=1, any S1/S2 entry whose tag lies strictly inside the circular window (mispredict_tag, curr_rob_tag) is invalidated, and its response is suppressed.
- REQ-026: While mispredict=1, a concurrent load request with an in-window tag is not granted (ld_req_ready=0 for it).
- REQ-027: Stores are never flushed.
- REQ-028: The flush window wraps modulo 32.
- REQ-029: When mispredict_tag == curr_rob_tag the flush window is empty.
- REQ-030: Store write and load read are ordered by grant cycle; a load granted the cycle after a same-word store returns the new data.

Reset
- REQ-031: While reset=1 (asynchronous), the following are 0: S1/S2 valids, starve_cnt, mem_en, mem_we, mem_addr, mem_wdata, and all ld_resp_* outputs.
- REQ-032: While reset=1, ld_req_ready=0 and st_req_ready=0.
- REQ-033: Loads in flight when reset asserts are discarded and produce no response after reset deasserts.

Configuration
- REQ-034: Macro DMEM_ARB_SUBWORD_EN defined: adds LB (000, sign-extended byte), LH (001, sign-extended half at addr[1]), LHU (101, zero-extended half) and SH (001, mem_we 0011/1100 by addr[1]).
- REQ-035: Macro DMEM_ARB_SUBWORD_EN undefined: those codes follow REQ-022 for loads, and an SH store is accepted with mem_we=0000 (no write).

Verification
- REQ-036: Memory holds 0x44332211 at word 0; LW addr 0, tag 1 -> ld_resp_valid exactly 2 cycles after grant with data 0x44332211, tag 1, pd 10.
- REQ-037: LBU addr 1 -> data 0x00000022; back-to-back LW@0 then LBU@1 in consecutive cycles -> responses in consecutive cycles, in order.
- REQ-038: SB addr 2 data 0xAB, then LW@0 next cycle -> mem_we=0100 on the store, load returns 0x44AB2211.
- REQ-039: Load tag 5 in flight; mispredict with mispredict_tag 3, curr_rob_tag 8 -> no response. Repeat with tag 9 -> response delivered. Repeat with mispredict_tag 30, curr_rob_tag 2, tag 31 -> flushed.
- REQ-040: st_req_valid held high for 10 cycles with ld_req_valid high -> load granted on the 5th grant cycle (after 4 store grants), then stores resume.
- REQ-041: Assert reset one cycle after a load grant -> all outputs 0 immediately; no ld_resp_valid after deassert.
